axis_read_header_injector: RTL

- Sits directly downstream of the AXI-Stream control wrapper's read (MM2S-side) master port and directly upstream of the DMA S2MM channel.
- On each READ command it emits a 6-word response header, then forwards the wrapper's payload beats.
- It generates frame TLAST from a beat counter and flags any mismatch with the upstream TLAST.
- Outputs are fully registered through a 2-entry skid buffer.

---
 rtl/axis_read_header_injector_pkg.sv | 30 +++
 rtl/axis_skid_buffer.sv | 63 ++++++
 rtl/axis_read_header_injector.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axis_read_header_injector_pkg.sv
// Constants and types shared by the read header injector and the command parser.
// The response status reuses the parser's READ opcode value.
package axis_read_header_injector_pkg;

    localparam logic [15:0] CMD_MAGIC      = 16'hC0DE;
    localparam logic [15:0] CMD_OP_READ    = 16'h0002;

    localparam logic [15:0] HDR_RESP_MAGIC = 16'hDA7A;
    localparam logic [15:0] STATUS_READ_OK = CMD_OP_READ;
    localparam int          STATUS_ERR_BIT = 15;
    localparam int          HDR_LEN        = 6;
    localparam int          HDR_IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    // Payload length of a READ: number of BRAMs in range times words per BRAM.
    function automatic logic [31:0] calc_beats(input logic [3:0] bram_start,
                                               input logic [3:0] bram_end,
                                               input logic [9:0] count);
        logic [4:0] span;
        span = {1'b0, bram_end} - {1'b0, bram_start} + 5'd1;
        return 32'(span) * 32'(count);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice carrying data+last; all outputs come
// straight from flops, and the upstream ready is registered as well.
module axis_skid_buffer #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] i_s_data,
    input  logic         i_s_last,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [W-1:0] o_m_data,
    output logic         o_m_last,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic         o_empty
);

    logic [W-1:0] r_m_data;
    logic         r_m_last;
    logic         r_m_vld;
    logic [W-1:0] r_s_data;
    logic         r_s_last;
    logic         r_s_vld;
    logic         w_load_main;

    assign w_load_main = !r_m_vld || i_m_ready;
    assign o_s_ready   = !r_s_vld;
    assign o_empty     = !r_m_vld && !r_s_vld;
    assign o_m_data    = r_m_data;
    assign o_m_last    = r_m_last;
    assign o_m_valid   = r_m_vld;

    // The skid entry only fills when the output is stalled; it drains first.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_data <= '0;
            r_m_last <= 1'b0;
            r_m_vld  <= 1'b0;
            r_s_data <= '0;
            r_s_last <= 1'b0;
            r_s_vld  <= 1'b0;
        end else if (w_load_main) begin
            if (r_s_vld) begin
                r_m_data <= r_s_data;
                r_m_last <= r_s_last;
                r_m_vld  <= 1'b1;
                r_s_vld  <= 1'b0;
            end else begin
                r_m_vld <= i_s_valid;
                if (i_s_valid) begin
                    r_m_data <= i_s_data;
                    r_m_last <= i_s_last;
                end
            end
        end else if (i_s_valid && !r_s_vld) begin
            r_s_data <= i_s_data;
            r_s_last <= i_s_last;
            r_s_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_read_header_injector.sv
// Prepends a 6-word response header to each READ payload, regenerates TLAST
// from a beat counter and flags disagreement with the upstream TLAST.
module axis_read_header_injector
    import axis_read_header_injector_pkg::*;
#(
    parameter int          DATA_WIDTH     = 16,
    parameter logic [15:0] RESP_MAGIC     = HDR_RESP_MAGIC,
    parameter int          BEAT_CNT_WIDTH = 14
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [3:0]            hdr_bram_start,
    input  logic [3:0]            hdr_bram_end,
    input  logic [8:0]            hdr_addr_start,
    input  logic [9:0]            hdr_count,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_range,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [3:0]                r_bram_start;
    logic [3:0]                r_bram_end;
    logic [8:0]                r_addr_start;
    logic [9:0]                r_count;
    logic                      r_range_bad;
    logic                      r_no_payload;
    logic [BEAT_CNT_WIDTH-1:0] r_remain;
    logic [HDR_IDX_W-1:0]      r_hdr_idx;
    logic                      r_err_range;
    logic                      r_err_early;
    logic                      r_err_missing;

    logic                      w_start_acc;
    logic                      w_range_bad;
    logic [BEAT_CNT_WIDTH-1:0] w_beats;
    logic                      w_final;
    logic                      w_hdr_last_word;
    logic [15:0]               w_status;
    logic [DATA_WIDTH-1:0]     w_hdr_word;
    logic [DATA_WIDTH-1:0]     w_push_data;
    logic                      w_push_last;
    logic                      w_push_vld;
    logic                      w_push_fire;
    logic                      w_skid_rdy;
    logic                      w_skid_empty;

    assign w_start_acc     = start && (r_state == ST_IDLE);
    assign w_range_bad     = hdr_bram_end < hdr_bram_start;
    assign w_beats         = BEAT_CNT_WIDTH'(calc_beats(hdr_bram_start, hdr_bram_end, hdr_count));
    assign w_final         = r_remain == BEAT_CNT_WIDTH'(1);
    assign w_hdr_last_word = r_hdr_idx == HDR_IDX_W'(HDR_LEN - 1);
    assign w_push_fire     = w_push_vld && w_skid_rdy;

    assign busy              = r_state != ST_IDLE;
    assign err_range         = r_err_range;
    assign err_tlast_early   = r_err_early;
    assign err_tlast_missing = r_err_missing;

    always_comb begin
        w_status                 = STATUS_READ_OK;
        w_status[STATUS_ERR_BIT] = r_range_bad;
    end

    always_comb begin
        w_hdr_word = '0;
        case (r_hdr_idx)
            3'd0:    w_hdr_word = DATA_WIDTH'(RESP_MAGIC);
            3'd1:    w_hdr_word = DATA_WIDTH'(w_status);
            3'd2:    w_hdr_word = DATA_WIDTH'(r_bram_start);
            3'd3:    w_hdr_word = DATA_WIDTH'(r_bram_end);
            3'd4:    w_hdr_word = DATA_WIDTH'(r_addr_start);
            3'd5:    w_hdr_word = DATA_WIDTH'(r_count);
            default: w_hdr_word = '0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_push_vld    = 1'b0;
        w_push_data   = '0;
        w_push_last   = 1'b0;
        s_axis_tready = 1'b0;
        frame_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                w_push_vld  = 1'b1;
                w_push_data = w_hdr_word;
                // Header-only frames end on word 5.
                w_push_last = w_hdr_last_word && r_no_payload;
                if (w_skid_rdy && w_hdr_last_word)
                    w_state_nxt = r_no_payload ? ST_DONE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                s_axis_tready = w_skid_rdy;
                w_push_vld    = s_axis_tvalid;
                w_push_data   = s_axis_tdata;
                w_push_last   = w_final || s_axis_tlast;
                if (w_push_fire && (w_final || s_axis_tlast)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Only this frame's beats were pushed, so empty means TLAST left.
                if (w_skid_empty) begin
                    frame_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_bram_start  <= '0;
            r_bram_end    <= '0;
            r_addr_start  <= '0;
            r_count       <= '0;
            r_range_bad   <= 1'b0;
            r_no_payload  <= 1'b0;
            r_remain      <= '0;
            r_hdr_idx     <= '0;
            r_err_range   <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_bram_start  <= hdr_bram_start;
                r_bram_end    <= hdr_bram_end;
                r_addr_start  <= hdr_addr_start;
                r_count       <= hdr_count;
                r_range_bad   <= w_range_bad;
                r_no_payload  <= w_range_bad || (w_beats == '0);
                r_remain      <= w_beats;
                r_hdr_idx     <= '0;
                r_err_range   <= w_range_bad;
                r_err_early   <= 1'b0;
                r_err_missing <= 1'b0;
            end
            if (r_state == ST_HDR && w_skid_rdy) r_hdr_idx <= r_hdr_idx + 1'b1;
            if (r_state == ST_PAYLOAD && w_push_fire) begin
                r_remain <= r_remain - 1'b1;
                if (w_final && !s_axis_tlast)      r_err_missing <= 1'b1;
                else if (!w_final && s_axis_tlast) r_err_early   <= 1'b1;
            end
        end
    end

    axis_skid_buffer #(
        .W (DATA_WIDTH)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_s_data  (w_push_data),
        .i_s_last  (w_push_last),
        .i_s_valid (w_push_vld),
        .o_s_ready (w_skid_rdy),
        .o_m_data  (m_axis_tdata),
        .o_m_last  (m_axis_tlast),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready),
        .o_empty   (w_skid_empty)
    );

endmodule
